// File: rtl/ascii2key_seq.sv
// ASCII-to-PS/2 Set-2 keystroke sequencer: one character in, make/break byte stream out,
// with left-Shift wrapping for shifted characters and an optional idle gap between bytes.
module ascii2key_seq #(
  parameter logic [7:0] BREAK_CODE = 8'hF0,
  parameter logic [7:0] SHIFT_CODE = 8'h12,
  parameter int         GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       unsupported,
  output logic       busy
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SH_MK    = 4'd1;
  localparam logic [3:0] S_MK       = 4'd2;
  localparam logic [3:0] S_BRK      = 4'd3;
  localparam logic [3:0] S_BRK_CODE = 4'd4;
  localparam logic [3:0] S_SH_BRK0  = 4'd5;
  localparam logic [3:0] S_SH_BRK1  = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_UNSUP    = 4'd8;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  function automatic logic [7:0] letter_code(input logic [7:0] idx);
    logic [7:0] c;
    case (idx)
      8'd0:  c = 8'h1C;  8'd1:  c = 8'h32;  8'd2:  c = 8'h21;  8'd3:  c = 8'h23;
      8'd4:  c = 8'h24;  8'd5:  c = 8'h2B;  8'd6:  c = 8'h34;  8'd7:  c = 8'h33;
      8'd8:  c = 8'h43;  8'd9:  c = 8'h3B;  8'd10: c = 8'h42;  8'd11: c = 8'h4B;
      8'd12: c = 8'h3A;  8'd13: c = 8'h31;  8'd14: c = 8'h44;  8'd15: c = 8'h4D;
      8'd16: c = 8'h15;  8'd17: c = 8'h2D;  8'd18: c = 8'h1B;  8'd19: c = 8'h2C;
      8'd20: c = 8'h3C;  8'd21: c = 8'h2A;  8'd22: c = 8'h1D;  8'd23: c = 8'h22;
      8'd24: c = 8'h35;  8'd25: c = 8'h1A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] digit_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd1: c = 8'h16;  4'd2: c = 8'h1E;  4'd3: c = 8'h26;  4'd4: c = 8'h25;
      4'd5: c = 8'h2E;  4'd6: c = 8'h36;  4'd7: c = 8'h3D;  4'd8: c = 8'h3E;
      4'd9: c = 8'h46;  4'd0: c = 8'h45;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Result is {supported, shift, scan_code}.
  function automatic logic [9:0] map_ascii(input logic [7:0] ch);
    logic [9:0] m;
    m = 10'd0;
    if (ch >= 8'h61 && ch <= 8'h7A)      m = {2'b10, letter_code(ch - 8'h61)};
    else if (ch >= 8'h41 && ch <= 8'h5A) m = {2'b11, letter_code(ch - 8'h41)};
    else if (ch >= 8'h30 && ch <= 8'h39) m = {2'b10, digit_code(ch[3:0])};
    else begin
      case (ch)
        8'h21: m = {2'b11, digit_code(4'd1)};
        8'h40: m = {2'b11, digit_code(4'd2)};
        8'h23: m = {2'b11, digit_code(4'd3)};
        8'h24: m = {2'b11, digit_code(4'd4)};
        8'h25: m = {2'b11, digit_code(4'd5)};
        8'h5E: m = {2'b11, digit_code(4'd6)};
        8'h26: m = {2'b11, digit_code(4'd7)};
        8'h2A: m = {2'b11, digit_code(4'd8)};
        8'h28: m = {2'b11, digit_code(4'd9)};
        8'h29: m = {2'b11, digit_code(4'd0)};
        8'h20: m = {2'b10, 8'h29};
        8'h0D: m = {2'b10, 8'h5A};
        8'h08: m = {2'b10, 8'h66};
        default: m = 10'd0;
      endcase
    end
    return m;
  endfunction

  logic [3:0] r_state;
  logic [3:0] w_state_nxt;
  logic [7:0] r_code;
  logic       r_shift;
  logic [7:0] r_gap;
  logic [9:0] w_map;
  logic       w_accept;
  logic       w_xfer;
  logic       w_byte_state;
  logic       w_last;

  assign w_map        = map_ascii(ascii_in);
  assign ascii_ready  = (r_state == S_IDLE);
  assign w_accept     = ascii_valid & ascii_ready;
  assign w_byte_state = (r_state >= S_SH_MK) && (r_state <= S_SH_BRK1);
  assign code_valid   = w_byte_state && (r_gap == 8'd0);
  assign w_xfer       = code_valid & code_ready;
  assign w_last       = ((r_state == S_BRK_CODE) && !r_shift) || (r_state == S_SH_BRK1);
  assign unsupported  = (r_state == S_UNSUP);
  assign busy         = (r_state != S_IDLE);

  always_comb begin
    code_out = 8'h00;
    case (r_state)
      S_SH_MK:    code_out = SHIFT_CODE;
      S_MK:       code_out = r_code;
      S_BRK:      code_out = BREAK_CODE;
      S_BRK_CODE: code_out = r_code;
      S_SH_BRK0:  code_out = BREAK_CODE;
      S_SH_BRK1:  code_out = SHIFT_CODE;
      default:    code_out = 8'h00;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (!w_map[9])     w_state_nxt = S_UNSUP;
        else if (w_map[8]) w_state_nxt = S_SH_MK;
        else               w_state_nxt = S_MK;
      end
      S_SH_MK:    if (w_xfer) w_state_nxt = S_MK;
      S_MK:       if (w_xfer) w_state_nxt = S_BRK;
      S_BRK:      if (w_xfer) w_state_nxt = S_BRK_CODE;
      S_BRK_CODE: if (w_xfer) w_state_nxt = r_shift ? S_SH_BRK0 : S_DONE;
      S_SH_BRK0:  if (w_xfer) w_state_nxt = S_SH_BRK1;
      S_SH_BRK1:  if (w_xfer) w_state_nxt = S_DONE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Control state; the gap is loaded on every non-final transfer and counts down to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_shift <= 1'b0;
      r_gap   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_shift <= w_map[8];
      if (w_xfer && !w_last) r_gap <= GAP_LOAD;
      else if (r_gap != 8'd0) r_gap <= r_gap - 8'd1;
    end
  end

  // Scan code is pure data and is only observed through byte states.
  always_ff @(posedge clk) begin
    if (w_accept) r_code <= w_map[7:0];
  end

endmodule

// File: tb/tb_ascii2key_seq.sv
// Directed bench for ascii2key_seq: one instance with no gap, one with GAP_CYCLES=3.
module tb_ascii2key_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ascii_in;
  logic       ascii_valid;
  logic       ascii_ready;
  logic [7:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic       unsupported;
  logic       busy;

  logic [7:0] g_ascii_in;
  logic       g_ascii_valid;
  logic       g_ascii_ready;
  logic [7:0] g_code_out;
  logic       g_code_valid;
  logic       g_code_ready;
  logic       g_unsupported;
  logic       g_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ascii2key_seq u_dut (
    .clk(clk), .reset_n(reset_n), .ascii_in(ascii_in), .ascii_valid(ascii_valid),
    .ascii_ready(ascii_ready), .code_out(code_out), .code_valid(code_valid),
    .code_ready(code_ready), .unsupported(unsupported), .busy(busy)
  );

  ascii2key_seq #(.GAP_CYCLES(3)) u_dut_gap (
    .clk(clk), .reset_n(reset_n), .ascii_in(g_ascii_in), .ascii_valid(g_ascii_valid),
    .ascii_ready(g_ascii_ready), .code_out(g_code_out), .code_valid(g_code_valid),
    .code_ready(g_code_ready), .unsupported(g_unsupported), .busy(g_busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input string tag, input logic [7:0] c);
    chk({tag, "_ready_before"}, {7'd0, ascii_ready}, 8'd1);
    ascii_in    = c;
    ascii_valid = 1'b1;
    tick();
    ascii_valid = 1'b0;
    ascii_in    = 8'h00;
  endtask

  task automatic done_checks(input string tag);
    chk({tag, "_done_valid"}, {7'd0, code_valid}, 8'd0);
    chk({tag, "_done_busy"}, {7'd0, busy}, 8'd1);
    chk({tag, "_done_ready"}, {7'd0, ascii_ready}, 8'd0);
    tick();
    chk({tag, "_idle_ready"}, {7'd0, ascii_ready}, 8'd1);
    chk({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
  endtask

  // Bytes packed MSB-first; code_ready assumed high throughout.
  task automatic stream(input string tag, input logic [47:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, {7'd0, code_valid}, 8'd1);
      chk({tag, "_byte"}, code_out, exp[47-8*i -: 8]);
      chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
      chk({tag, "_ascii_ready"}, {7'd0, ascii_ready}, 8'd0);
      tick();
    end
    done_checks(tag);
  endtask

  task automatic stream_stall(input string tag, input logic [47:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      code_ready = 1'b0;
      chk({tag, "_valid"}, {7'd0, code_valid}, 8'd1);
      chk({tag, "_byte"}, code_out, exp[47-8*i -: 8]);
      tick();
      chk({tag, "_hold_valid"}, {7'd0, code_valid}, 8'd1);
      chk({tag, "_hold_byte"}, code_out, exp[47-8*i -: 8]);
      code_ready = 1'b1;
      tick();
    end
    done_checks(tag);
  endtask

  initial begin
    reset_n       = 1'b0;
    ascii_in      = 8'h00;
    ascii_valid   = 1'b0;
    code_ready    = 1'b0;
    g_ascii_in    = 8'h00;
    g_ascii_valid = 1'b0;
    g_code_ready  = 1'b0;
    tick();
    chk("rst_ascii_ready", {7'd0, ascii_ready}, 8'd1);
    chk("rst_code_valid", {7'd0, code_valid}, 8'd0);
    chk("rst_code_out", code_out, 8'h00);
    chk("rst_unsupported", {7'd0, unsupported}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_gap_ready", {7'd0, g_ascii_ready}, 8'd1);
    reset_n = 1'b1;
    tick();

    code_ready = 1'b1;
    send_char("a", 8'h61);
    stream("a", {8'h1C, 8'hF0, 8'h1C, 24'h0}, 3);

    send_char("H", 8'h48);
    stream("H", {8'h12, 8'h33, 8'hF0, 8'h33, 8'hF0, 8'h12}, 6);

    send_char("rparen", 8'h29);
    stream_stall("rparen", {8'h12, 8'h45, 8'hF0, 8'h45, 8'hF0, 8'h12}, 6);
    code_ready = 1'b1;
    send_char("space", 8'h20);
    stream("space", {8'h29, 8'hF0, 8'h29, 24'h0}, 3);

    send_char("tilde", 8'h7E);
    chk("tilde_unsup", {7'd0, unsupported}, 8'd1);
    chk("tilde_valid", {7'd0, code_valid}, 8'd0);
    chk("tilde_ready", {7'd0, ascii_ready}, 8'd0);
    chk("tilde_busy", {7'd0, busy}, 8'd1);
    tick();
    chk("tilde_unsup_end", {7'd0, unsupported}, 8'd0);
    chk("tilde_valid_end", {7'd0, code_valid}, 8'd0);
    chk("tilde_ready_end", {7'd0, ascii_ready}, 8'd1);
    send_char("enter", 8'h0D);
    stream("enter", {8'h5A, 8'hF0, 8'h5A, 24'h0}, 3);

    send_char("A", 8'h41);
    chk("A_b1", code_out, 8'h12);
    tick();
    chk("A_b2", code_out, 8'h1C);
    tick();
    chk("A_b3", code_out, 8'hF0);
    code_ready = 1'b0;
    tick();
    chk("A_stall_valid", {7'd0, code_valid}, 8'd1);
    chk("A_stall_byte", code_out, 8'hF0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ascii_ready", {7'd0, ascii_ready}, 8'd1);
    chk("arst_code_valid", {7'd0, code_valid}, 8'd0);
    chk("arst_code_out", code_out, 8'h00);
    chk("arst_unsupported", {7'd0, unsupported}, 8'd0);
    chk("arst_busy", {7'd0, busy}, 8'd0);
    #1 reset_n = 1'b1;
    tick();
    code_ready = 1'b1;
    chk("post_rst_valid", {7'd0, code_valid}, 8'd0);
    chk("post_rst_busy", {7'd0, busy}, 8'd0);
    tick();
    chk("post_rst_valid2", {7'd0, code_valid}, 8'd0);
    send_char("bksp", 8'h08);
    stream("bksp", {8'h66, 8'hF0, 8'h66, 24'h0}, 3);

    g_code_ready = 1'b1;
    chk("gap_ready_before", {7'd0, g_ascii_ready}, 8'd1);
    g_ascii_in    = 8'h30;
    g_ascii_valid = 1'b1;
    tick();
    g_ascii_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("gap_valid", {7'd0, g_code_valid}, 8'd1);
      chk("gap_byte", g_code_out, (i == 1) ? 8'hF0 : 8'h45);
      tick();
      if (i < 2) begin
        for (int k = 0; k < 3; k++) begin
          chk("gap_idle_valid", {7'd0, g_code_valid}, 8'd0);
          chk("gap_idle_busy", {7'd0, g_busy}, 8'd1);
          tick();
        end
      end
    end
    chk("gap_done_valid", {7'd0, g_code_valid}, 8'd0);
    chk("gap_done_busy", {7'd0, g_busy}, 8'd1);
    chk("gap_done_ready", {7'd0, g_ascii_ready}, 8'd0);
    tick();
    chk("gap_idle_ready", {7'd0, g_ascii_ready}, 8'd1);
    chk("gap_unsup", {7'd0, g_unsupported}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
